fah_2_cel_seq: RTL and testbench

- Sequential Fahrenheit-to-Celsius converter; the inverse of the existing Celsius-to-Fahrenheit block.
- Computes C = trunc((F - 32) * 5 / 9) using a shift-add multiply and a radix-2 restoring divider, one quotient bit per cycle, with no hardware divider.
- Valid/ready handshake on both sides; sits between the temperature-input datapath and the display/reporting path.

---
 rtl/fah_2_cel_seq.sv | 150 +++++++++++++++
 tb/tb_fah_2_cel_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fah_2_cel_seq.sv
// ---------------------------------------------------------------------------
// fah_2_cel_seq
// Sequential Fahrenheit-to-Celsius converter: C = trunc((F - 32) * 5 / 9).
// The *5 is a shift-add. The /9 is a radix-2 restoring divider that produces
// one quotient bit per cycle. The divider works on the magnitude, so the
// result is truncated toward zero and then negated if needed.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   fahren is valid
//   in_ready   block can accept an input (high only in IDLE)
//   fahren     signed Fahrenheit input, WIDTH bits
//   out_valid  celsius/out_rem are valid
//   out_ready  consumer accepts the result
//   celsius    signed Celsius result, truncated toward zero
//   out_rem    magnitude of the division remainder (0..8)
// ---------------------------------------------------------------------------
module fah_2_cel_seq #(
   parameter  int WIDTH = 16,
   localparam int DW    = WIDTH + 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] fahren,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] celsius,
   output logic [3:0]       out_rem
);

   localparam int CW = $clog2(DW);

   typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;

   state_t                  state;
   logic signed [WIDTH-1:0] fahren_r;
   logic                    sign_r;
   logic        [DW-1:0]    dvd_r;
   logic        [3:0]       rem_r;
   logic        [WIDTH-1:0] quot_r;
   logic        [CW-1:0]    cnt_r;

   // Two's-complement magnitude of the scaled value
   function automatic logic [DW-1:0] abs_dw(input logic [DW-1:0] v);
      return v[DW-1] ? (~v + 1'b1) : v;
   endfunction

   // Negate the truncated magnitude when the input lay below 32 F
   function automatic logic [WIDTH-1:0] apply_sign(input logic s,
                                                   input logic [WIDTH-1:0] m);
      return s ? (~m + 1'b1) : m;
   endfunction

   // ---- PREP datapath: d = F - 32, p = 5*d -------------------------------
   logic signed [WIDTH:0]  diff;
   logic signed [DW-1:0]   diff_x;
   logic signed [DW-1:0]   prod;

   always_comb begin
      diff   = {fahren_r[WIDTH-1], fahren_r} - (WIDTH+1)'(32);
      diff_x = {{2{diff[WIDTH]}}, diff};
      prod   = (diff_x <<< 2) + diff_x;
   end

   // ---- DIV datapath: one restoring step per cycle -----------------------
   // The remainder stays below 9 between steps, so after the shift it fits in
   // 5 bits and after a subtract it fits in 4 bits again.
   logic [4:0] rem_sh;
   logic       ge9;
   logic [3:0] rem_nx;

   always_comb begin
      rem_sh = {rem_r, dvd_r[DW-1]};
      ge9    = (rem_sh >= 5'd9);
      rem_nx = ge9 ? 4'(rem_sh - 5'd9) : rem_sh[3:0];
   end

   // ---- Control FSM and registered outputs -------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         celsius   <= '0;
         out_rem   <= '0;
         fahren_r  <= '0;
         sign_r    <= 1'b0;
         dvd_r     <= '0;
         rem_r     <= '0;
         quot_r    <= '0;
         cnt_r     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  fahren_r <= fahren;
                  in_ready <= 1'b0;
                  state    <= PREP;
               end
            end

            PREP: begin
               sign_r <= prod[DW-1];
               dvd_r  <= abs_dw(prod);
               rem_r  <= '0;
               quot_r <= '0;
               cnt_r  <= CW'(DW - 1);
               state  <= DIV;
            end

            // The quotient is shifted through a WIDTH-bit register. The bits that
            // fall off the top are always zero because |C| < 2^(WIDTH-1).
            DIV: begin
               rem_r  <= rem_nx;
               quot_r <= {quot_r[WIDTH-2:0], ge9};
               dvd_r  <= {dvd_r[DW-2:0], 1'b0};
               if (cnt_r == '0)
                  state <= FIX;
               else
                  cnt_r <= cnt_r - 1'b1;
            end

            FIX: begin
               celsius   <= apply_sign(sign_r, quot_r);
               out_rem   <= rem_r;
               out_valid <= 1'b1;
               state     <= DONE;
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fah_2_cel_seq.sv
// ---------------------------------------------------------------------------
// tb_fah_2_cel_seq
// Scoreboard bench for fah_2_cel_seq. The stimulus side pushes the expected
// (celsius, remainder) pair when an input is accepted. A monitor pops and
// compares on every output transfer.
// ---------------------------------------------------------------------------
module tb_fah_2_cel_seq;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] fahren;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] celsius;
   logic [3:0]       out_rem;

   fah_2_cel_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fahren    (fahren),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .celsius   (celsius),
      .out_rem   (out_rem)
   );

   always #5 clk = ~clk;

   typedef struct {
      int c;
      int r;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;
   int   acc_cyc = 0;
   bit   busy    = 1'b0;
   bit   viol    = 1'b0;
   bit   rnd     = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   function automatic exp_t model(input int f);
      exp_t e;
      int   p;
      p   = (f - 32) * 5;
      e.c = p / 9;
      e.r = (p % 9 < 0) ? -(p % 9) : (p % 9);
      return e;
   endfunction

   // Monitor: compare on each output transfer
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy && in_ready) viol = 1'b1;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected result", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("celsius", int'($signed(celsius)), e.c);
               chk("out_rem", int'(out_rem), e.r);
            end
            chk("in_ready low while busy", int'(viol), 0);
            viol = 1'b0;
            busy = 1'b0;
         end
      end
   end

   // Random back-pressure during the randomised phase
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Drive one input, wait (bounded) for acceptance, push the expectation
   task automatic send(input int f);
      int n;
      bit acc;
      n   = 0;
      acc = 1'b0;
      fahren   = WIDTH'(f);
      in_valid = 1'b1;
      while (!acc && n < 300) begin
         @(negedge clk);
         if (in_ready) acc = 1'b1;
         else n++;
      end
      if (acc) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         acc_cyc  = cyc;
         busy     = 1'b1;
         sb.push_back(model(f));
      end else begin
         in_valid = 1'b0;
         chk("accept timeout", 0, 1);
      end
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain pending results", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int  n;
      bit  stable;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      fahren    = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", int'(in_ready), 1);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset celsius", int'(celsius), 0);
      chk("reset out_rem", int'(out_rem), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 212 F: latency and single-cycle out_valid
      send(212);
      n = 0;
      while (n < 60) begin
         @(negedge clk);
         if (out_valid) break;
         n++;
      end
      chk("latency edges", cyc - acc_cyc, 21);
      @(negedge clk);
      chk("out_valid one cycle", int'(out_valid), 0);
      wait_empty();

      // Back-to-back sequence
      send(32);
      send(-40);
      send(100);
      send(0);
      wait_empty();

      // Extremes
      send(-32768);
      send(32767);
      wait_empty();

      // Hold under back-pressure, ignored in_valid pulses
      out_ready = 1'b0;
      send(98);
      n = 0;
      while (!out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (int'($signed(celsius)) != 36 || out_rem != 4'd6 || !out_valid || in_ready)
            stable = 1'b0;
         if (i == 3) begin
            fahren   = WIDTH'(5);
            in_valid = 1'b1;
         end
         if (i == 6) in_valid = 1'b0;
      end
      chk("hold stable under back-pressure", int'(stable), 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("after release out_valid", int'(out_valid), 0);
      chk("after release in_ready", int'(in_ready), 1);
      repeat (30) @(posedge clk);
      #1;
      chk("ignored in_valid gave no result", int'(out_valid), 0);
      wait_empty();

      // Asynchronous reset mid-DIV
      send(212);
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async rst out_valid", int'(out_valid), 0);
      chk("async rst in_ready", int'(in_ready), 1);
      chk("async rst celsius", int'(celsius), 0);
      sb.delete();
      busy = 1'b0;
      viol = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(50);
      wait_empty();

      // Randomised inputs with random gaps and back-pressure
      rnd = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         send(int'($signed(16'($urandom_range(0, 65535)))));
      end
      wait_empty();
      rnd = 1'b0;
      out_ready = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
